// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: data-first fixed priority with fetch anti-starvation.
// Define MEM_ARB_PERF_EN to build the grant/wait performance counters.
module mem_arbiter #(
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        mem_oe,
   input  logic [31:0] mem_rdata,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_i_wait
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

   state_t      state_q, state_d;
   logic [3:0]  lat_q, lat_d;
   logic [3:0]  starve_q, starve_d;
   logic        own_d_q, own_d_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] irdata_q, irdata_d;
   logic [31:0] drdata_q, drdata_d;
   logic        grant_d;
   logic        issue;

   // Data wins contention unless fetch has lost STARVE_LIMIT times in a row.
   assign grant_d = d_req && !(i_req && starve_q == LIMIT);
   assign issue   = (state_q == IDLE) && (i_req || d_req);

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      starve_d = starve_q;
      own_d_d  = own_d_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      irdata_d = irdata_q;
      drdata_d = drdata_q;
      unique case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = ACCESS;
               lat_d   = LAT_INIT;
               own_d_d = grant_d;
               we_d    = grant_d && d_we;
               addr_d  = grant_d ? d_addr : i_addr;
               if (grant_d && d_we) begin
                  wdata_d = d_wdata;
               end
               if (grant_d && i_req) begin
                  if (starve_q != LIMIT) begin
                     starve_d = starve_q + 4'd1;
                  end
               end else begin
                  starve_d = 4'd0;
               end
            end
         end
         ACCESS: begin
            if (we_q) begin
               state_d = RESP;
            end else if (lat_q != 4'd0) begin
               lat_d = lat_q - 4'd1;
            end else begin
               state_d = RESP;
               if (own_d_q) begin
                  drdata_d = mem_rdata;
               end else begin
                  irdata_d = mem_rdata;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         lat_q    <= 4'd0;
         starve_q <= 4'd0;
         own_d_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         irdata_q <= 32'd0;
         drdata_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         starve_q <= starve_d;
         own_d_q  <= own_d_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         irdata_q <= irdata_d;
         drdata_q <= drdata_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_oe    = (state_q == ACCESS) && !we_q;
   assign mem_we    = (state_q == ACCESS) && we_q;
   assign i_ack     = (state_q == RESP) && !own_d_q;
   assign d_ack     = (state_q == RESP) && own_d_q;
   assign i_rdata   = irdata_q;
   assign d_rdata   = drdata_q;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] pig_q, pdg_q, piw_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pig_q <= 32'd0;
         pdg_q <= 32'd0;
         piw_q <= 32'd0;
      end else begin
         if (issue && grant_d) begin
            pdg_q <= pdg_q + 32'd1;
         end
         if (issue && !grant_d) begin
            pig_q <= pig_q + 32'd1;
         end
         if (i_req && !i_ack) begin
            piw_q <= piw_q + 32'd1;
         end
      end
   end

   assign perf_i_grants = pig_q;
   assign perf_d_grants = pdg_q;
   assign perf_i_wait   = piw_q;
`else
   assign perf_i_grants = 32'd0;
   assign perf_d_grants = 32'd0;
   assign perf_i_wait   = 32'd0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and data port.
- Uses request/acknowledge handshakes and data-first fixed priority, with an anti-starvation counter so fetch cannot be locked out.
- Sits between the core and the memory model/SRAM, replacing the split instruction/data memories.
- Sequences each access through a small FSM that honours a fixed memory read latency.

Parameters:
- MEM_LATENCY, 1, cycles mem_rdata becomes valid after mem_addr/mem_oe are presented (1..15).
- STARVE_LIMIT, 4, consecutive data grants that lose to a pending fetch before fetch is forced through (1..15).

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address.
- i_rdata  out  32  fetch data; valid when i_ack=1, held until the next fetch completes.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data; valid when d_ack=1, held until the next data read completes.
- d_ack  out  1  one-cycle data completion pulse.
- mem_addr  out  32  registered memory address.
- mem_wdata  out  32  registered write data.
- mem_we  out  1  memory write strobe.
- mem_oe  out  1  memory read enable.
- mem_rdata  in  32  memory read data.
- perf_i_grants  out  32  fetch grant count (optional feature).
- perf_d_grants  out  32  data grant count (optional feature).
- perf_i_wait  out  32  cycles with i_req=1 and i_ack=0 (optional feature).

Behaviour:
- Reset values: FSM=IDLE; i_ack=d_ack=mem_we=mem_oe=0; mem_addr, mem_wdata, i_rdata, d_rdata, starve_cnt = 0; perf counters 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, request present:
  - Select a winner.
  - At the edge, register mem_addr (and, for data writes, mem_wdata and the write flag).
  - Load lat_cnt = MEM_LATENCY-1 and go to ACCESS.
- Arbitration, only one requester pending: that requester wins.
- Arbitration, both pending:
  - Data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - starve_cnt increments on a data grant while i_req=1.
  - starve_cnt clears on a fetch grant, or on a data grant while i_req=0.
  - starve_cnt saturates at STARVE_LIMIT.
- ACCESS, read:
  - mem_oe=1 throughout; mem_addr is stable.
  - lat_cnt>0: decrement lat_cnt.
  - lat_cnt==0: capture mem_rdata into the winner's rdata register and go to RESP.
- ACCESS, write: mem_we=1 for exactly this one cycle, then go to RESP. lat_cnt is ignored and d_rdata is unchanged.
- RESP:
  - Winner's ack = 1 for exactly one cycle; then go to IDLE.
  - The requester changes its fields or drops req at the edge ending RESP.
  - req still high in the following IDLE cycle is a new transaction.
- Latency per transaction:
  - Read: 1 IDLE + MEM_LATENCY ACCESS + 1 RESP cycles; ack in cycle MEM_LATENCY+1 after the issue edge.
  - Write: 3 cycles.
- A transaction in flight is never pre-empted. A request arriving during ACCESS/RESP waits for IDLE.
- Only the current owner's request fields are sampled, and only at the IDLE edge; changes after issue are ignored.
- Simultaneous d_req and i_req on the cycle after a RESP: normal arbitration applies.
- rst mid-operation:
  - Abort the transaction and return to IDLE next cycle; no ack is issued.
  - A write is suppressed if rst is sampled at the edge that would enter ACCESS.
  - A write already in ACCESS completes at the memory but is not acked.
- Address is passed through unmodified; alignment and range are the memory's concern.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: three 32-bit wrapping counters.
  - perf_i_grants and perf_d_grants increment on the IDLE→ACCESS edge for that port.
  - perf_i_wait increments every cycle with i_req=1 and i_ack=0.
  - All three clear on rst.
- Undefined: perf ports are tied to 0 and no counter flops exist.

Test Plan:
- Single fetch, MEM_LATENCY=1, mem[0x10]=0xDEADBEEF, i_req with i_addr=0x10: i_ack pulses in cycle 2 after the issue edge with i_rdata=0xDEADBEEF; mem_oe high for 1 cycle; d_ack stays 0.
- Data write then read, d_addr=0x40, d_wdata=0x12345678: mem_we high exactly 1 cycle and d_ack after 3 cycles. A following read returns d_rdata=0x12345678 and i_rdata is unchanged.
- Contention, STARVE_LIMIT=4, i_req and d_req held continuously:
  - Grant sequence D,D,D,D,I,D,D,D,D,I.
  - perf_d_grants=8 and perf_i_grants=2 with MEM_ARB_PERF_EN.
- MEM_LATENCY=3 read: mem_oe high 3 consecutive cycles with stable mem_addr; ack on the 4th cycle after issue; mem_rdata changed before the final ACCESS cycle is ignored.
- rst asserted in the first ACCESS cycle of a read: no ack; next cycle FSM=IDLE and mem_oe=0; a re-issued request completes normally.
- Back-to-back fetches at 0x0 and 0x4 with req held high: exactly one idle cycle between i_ack pulses; no duplicate ack.
